// File: rtl/config_pkg.sv
// Shared PMA types: rule record, attribute bit positions, channel state
// and the overflow-safe range test used by every lookup port.
package config_pkg;

    localparam int unsigned NrMaxRules = 16;

    // Attribute bit positions within pma_rule_t.attr.
    localparam int unsigned PMA_NONIDEM = 0;
    localparam int unsigned PMA_EXEC    = 1;
    localparam int unsigned PMA_CACHE   = 2;

    typedef struct packed {
        logic        valid;
        logic        lock;
        logic [2:0]  attr;
        logic [63:0] base;
        logic [63:0] len;
    } pma_rule_t;

    typedef enum logic {ChIdle, ChFull} ch_state_e;

    // True when address lies in [base, base+len). The 65-bit sum keeps regions
    // ending exactly at 2^64 (or beyond) correct; len == 0 never matches.
    function automatic logic range_check(input logic [63:0] base,
                                         input logic [63:0] len,
                                         input logic [63:0] address);
        logic [64:0] top;
        top = {1'b0, base} + {1'b0, len};
        return (address >= base) && ({1'b0, address} < top);
    endfunction

endpackage

// File: rtl/cva6_pma_lookup.sv
// Combinational table match for one address: OR of hits and attributes over
// all valid matching rules, falling back to the default set on a miss.
module cva6_pma_lookup
    import config_pkg::*;
#(
    parameter int unsigned NrRules     = 16,
    parameter int unsigned AddrWidth   = 64,
    parameter logic [2:0]  DefaultAttr = 3'b010
) (
    input  pma_rule_t [NrRules-1:0] rules,
    input  logic [AddrWidth-1:0]    addr,
    output logic                    hit,
    output logic [2:0]              attr
);

    logic [63:0]        addr_ext;
    logic [NrRules-1:0] match;
    logic [2:0]         attr_or;
    logic [NrRules-1:0] lock_bits;
    logic               unused_lock;

    assign addr_ext = 64'(addr);

    // Lock bits only matter to the write path.
    for (genvar k = 0; k < NrRules; k++) begin : g_lock
        assign lock_bits[k] = rules[k].lock;
    end
    assign unused_lock = ^lock_bits;

    // Per-rule match and OR-reduction of attributes over all matching rules.
    always_comb begin
        match   = '0;
        attr_or = '0;
        for (int unsigned k = 0; k < NrRules; k++) begin
            if (rules[k].valid && range_check(rules[k].base, rules[k].len, addr_ext)) begin
                match[k] = 1'b1;
                attr_or  = attr_or | rules[k].attr;
            end
        end
    end

    assign hit  = |match;
    assign attr = hit ? attr_or : DefaultAttr;

endmodule

// File: rtl/cva6_pma_checker.sv
// Runtime-programmable PMA checker: register-backed rule table with lock bits
// and NrPorts independent lookup channels, each with a one-deep output register.
module cva6_pma_checker
    import config_pkg::*;
#(
    parameter int unsigned            NrRules     = 16,
    parameter int unsigned            NrPorts     = 2,
    parameter int unsigned            AddrWidth   = 64,
    parameter pma_rule_t [NrRules-1:0] RstRules   = '0,
    parameter logic [2:0]             DefaultAttr = 3'b010,
    localparam int unsigned           IdxWidth    = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                cfg_we_i,
    input  logic [IdxWidth-1:0]                 cfg_idx_i,
    input  pma_rule_t                           cfg_rule_i,
    output logic                                cfg_err_o,
    output pma_rule_t [NrRules-1:0]             cfg_rule_o,
    input  logic [NrPorts-1:0]                  req_valid_i,
    output logic [NrPorts-1:0]                  req_ready_o,
    input  logic [NrPorts-1:0][AddrWidth-1:0]   req_addr_i,
    output logic [NrPorts-1:0]                  resp_valid_o,
    input  logic [NrPorts-1:0]                  resp_ready_i,
    output logic [NrPorts-1:0]                  resp_hit_o,
    output logic [NrPorts-1:0][2:0]             resp_attr_o
);

    pma_rule_t [NrRules-1:0] rules_q;
    logic                    cfg_err_q;
    logic                    idx_in_range;
    logic                    target_lock;
    logic                    write_ok;

    assign idx_in_range = (32'(cfg_idx_i) < NrRules);

    // Lock bit of the entry addressed by the current write.
    always_comb begin
        target_lock = 1'b0;
        for (int unsigned k = 0; k < NrRules; k++) begin
            if (IdxWidth'(k) == cfg_idx_i) begin
                target_lock = rules_q[k].lock;
            end
        end
    end

    assign write_ok = idx_in_range && !target_lock;

    // Rule table update; rejected writes raise a one-cycle error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rules_q   <= RstRules;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we_i && !write_ok;
            for (int unsigned k = 0; k < NrRules; k++) begin
                if (cfg_we_i && write_ok && (IdxWidth'(k) == cfg_idx_i)) begin
                    rules_q[k] <= cfg_rule_i;
                end
            end
        end
    end

    assign cfg_err_o  = cfg_err_q;
    assign cfg_rule_o = rules_q;

    for (genvar p = 0; p < NrPorts; p++) begin : g_port
        logic      look_hit;
        logic [2:0] look_attr;
        logic      handshake;
        ch_state_e state_q;
        logic      hit_q;
        logic [2:0] attr_q;

        cva6_pma_lookup #(
            .NrRules     (NrRules),
            .AddrWidth   (AddrWidth),
            .DefaultAttr (DefaultAttr)
        ) u_lookup (
            .rules (rules_q),
            .addr  (req_addr_i[p]),
            .hit   (look_hit),
            .attr  (look_attr)
        );

        assign req_ready_o[p] = (state_q == ChIdle) || resp_ready_i[p];
        assign handshake      = req_valid_i[p] && req_ready_o[p];

        // Output register: lookups use the pre-write table of the accept cycle.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= ChIdle;
                hit_q   <= 1'b0;
                attr_q  <= 3'b000;
            end else if (handshake) begin
                state_q <= ChFull;
                hit_q   <= look_hit;
                attr_q  <= look_attr;
            end else if (resp_ready_i[p]) begin
                state_q <= ChIdle;
            end
        end

        assign resp_valid_o[p] = (state_q == ChFull);
        assign resp_hit_o[p]   = hit_q;
        assign resp_attr_o[p]  = attr_q;
    end

endmodule

// File: tb/tb_cva6_pma_checker.sv
// Directed bench for cva6_pma_checker: reset image, lock, write/lookup race,
// backpressure, top-of-range overflow and overlapping rules across ports.
module tb_cva6_pma_checker;
    import config_pkg::*;

    localparam int unsigned NR = 16;
    localparam int unsigned NP = 2;
    localparam int unsigned AW = 64;
    localparam int unsigned RB = $bits(pma_rule_t);

    localparam pma_rule_t R0 = '{valid: 1'b1, lock: 1'b0, attr: 3'b110,
                                 base: 64'h8000_0000, len: 64'h1000};
    localparam logic [NR*RB-1:0] RST_FLAT = {{((NR-1)*RB){1'b0}}, R0};

    logic                     clk;
    logic                     rst;
    logic                     cfg_we;
    logic [3:0]               cfg_idx;
    pma_rule_t                cfg_rule;
    logic                     cfg_err;
    pma_rule_t [NR-1:0]       cfg_rule_o;
    logic [NP-1:0]            req_valid;
    logic [NP-1:0]            req_ready;
    logic [NP-1:0][AW-1:0]    req_addr;
    logic [NP-1:0]            resp_valid;
    logic [NP-1:0]            resp_ready;
    logic [NP-1:0]            resp_hit;
    logic [NP-1:0][2:0]       resp_attr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cva6_pma_checker #(
        .NrRules     (NR),
        .NrPorts     (NP),
        .AddrWidth   (AW),
        .RstRules    (RST_FLAT),
        .DefaultAttr (3'b010)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_we_i     (cfg_we),
        .cfg_idx_i    (cfg_idx),
        .cfg_rule_i   (cfg_rule),
        .cfg_err_o    (cfg_err),
        .cfg_rule_o   (cfg_rule_o),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_hit_o   (resp_hit),
        .resp_attr_o  (resp_attr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic pma_rule_t mk(input logic v, input logic l, input logic [2:0] a,
                                     input logic [63:0] b, input logic [63:0] n);
        mk = '{valid: v, lock: l, attr: a, base: b, len: n};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input pma_rule_t r);
        cfg_we   = 1'b1;
        cfg_idx  = 4'(idx);
        cfg_rule = r;
        step;
        cfg_we   = 1'b0;
    endtask

    task automatic drive_lookup(input int p, input logic [63:0] a);
        req_valid[p] = 1'b1;
        req_addr[p]  = a;
        step;
        req_valid[p] = 1'b0;
    endtask

    task automatic test_reset;
        resp_ready = 2'b00;
        apply_reset;
        #1;
        total_cnt++; if (resp_valid !== 2'b00) $display("FAIL reset_valid: got %b want 00", resp_valid); else pass_cnt++;
        total_cnt++; if (resp_hit !== 2'b00) $display("FAIL reset_hit: got %b want 00", resp_hit); else pass_cnt++;
        total_cnt++; if (resp_attr !== 6'b0) $display("FAIL reset_attr: got %b want 000000", resp_attr); else pass_cnt++;
        total_cnt++; if (req_ready !== 2'b11) $display("FAIL reset_ready: got %b want 11", req_ready); else pass_cnt++;
        total_cnt++; if (cfg_err !== 1'b0) $display("FAIL reset_err: got %b want 0", cfg_err); else pass_cnt++;
        total_cnt++; if (cfg_rule_o[0] !== R0) $display("FAIL reset_rule0: got %h want %h", cfg_rule_o[0], R0); else pass_cnt++;
        total_cnt++; if (cfg_rule_o[1] !== pma_rule_t'('0)) $display("FAIL reset_rule1: got %h want 0", cfg_rule_o[1]); else pass_cnt++;
        resp_ready = 2'b11;
    endtask

    task automatic test_reset_hit;
        drive_lookup(0, 64'h8000_0FFF);
        total_cnt++; if (resp_valid[0] !== 1'b1) $display("FAIL rh_valid0: got %b want 1", resp_valid[0]); else pass_cnt++;
        total_cnt++; if (resp_hit[0] !== 1'b1) $display("FAIL rh_hit0: got %b want 1", resp_hit[0]); else pass_cnt++;
        total_cnt++; if (resp_attr[0] !== 3'b110) $display("FAIL rh_attr0: got %b want 110", resp_attr[0]); else pass_cnt++;
        drive_lookup(1, 64'h8000_1000);
        total_cnt++; if (resp_valid[0] !== 1'b0) $display("FAIL rh_drain0: got %b want 0", resp_valid[0]); else pass_cnt++;
        total_cnt++; if (resp_valid[1] !== 1'b1) $display("FAIL rh_valid1: got %b want 1", resp_valid[1]); else pass_cnt++;
        total_cnt++; if (resp_hit[1] !== 1'b0) $display("FAIL rh_hit1: got %b want 0", resp_hit[1]); else pass_cnt++;
        total_cnt++; if (resp_attr[1] !== 3'b010) $display("FAIL rh_attr1: got %b want 010", resp_attr[1]); else pass_cnt++;
        drive_lookup(0, 64'h8000_0000);
        total_cnt++; if (resp_hit[0] !== 1'b1) $display("FAIL rh_base_hit: got %b want 1", resp_hit[0]); else pass_cnt++;
    endtask

    task automatic test_lock;
        pma_rule_t w1;
        pma_rule_t w2;
        w1 = mk(1'b1, 1'b1, 3'b001, 64'h1000, 64'h100);
        w2 = mk(1'b1, 1'b0, 3'b001, 64'h2000, 64'h100);
        cfg_write(3, w1);
        total_cnt++; if (cfg_err !== 1'b0) $display("FAIL lock_first_err: got %b want 0", cfg_err); else pass_cnt++;
        total_cnt++; if (cfg_rule_o[3] !== w1) $display("FAIL lock_first_rule: got %h want %h", cfg_rule_o[3], w1); else pass_cnt++;
        cfg_write(3, w2);
        total_cnt++; if (cfg_err !== 1'b1) $display("FAIL lock_err_pulse: got %b want 1", cfg_err); else pass_cnt++;
        total_cnt++; if (cfg_rule_o[3] !== w1) $display("FAIL lock_rule_kept: got %h want %h", cfg_rule_o[3], w1); else pass_cnt++;
        step;
        total_cnt++; if (cfg_err !== 1'b0) $display("FAIL lock_err_clear: got %b want 0", cfg_err); else pass_cnt++;
        apply_reset;
        total_cnt++; if (cfg_rule_o[3] !== pma_rule_t'('0)) $display("FAIL lock_rst_rule: got %h want 0", cfg_rule_o[3]); else pass_cnt++;
        cfg_write(3, w2);
        total_cnt++; if (cfg_err !== 1'b0) $display("FAIL lock_rst_err: got %b want 0", cfg_err); else pass_cnt++;
        total_cnt++; if (cfg_rule_o[3] !== w2) $display("FAIL lock_rst_write: got %h want %h", cfg_rule_o[3], w2); else pass_cnt++;
    endtask

    task automatic test_race;
        cfg_we       = 1'b1;
        cfg_idx      = 4'd1;
        cfg_rule     = mk(1'b1, 1'b0, 3'b101, 64'h9000_0000, 64'h1000);
        req_valid[0] = 1'b1;
        req_addr[0]  = 64'h9000_0010;
        step;
        cfg_we       = 1'b0;
        req_valid[0] = 1'b0;
        total_cnt++; if (resp_valid[0] !== 1'b1) $display("FAIL race_valid: got %b want 1", resp_valid[0]); else pass_cnt++;
        total_cnt++; if (resp_hit[0] !== 1'b0) $display("FAIL race_old_hit: got %b want 0", resp_hit[0]); else pass_cnt++;
        total_cnt++; if (resp_attr[0] !== 3'b010) $display("FAIL race_old_attr: got %b want 010", resp_attr[0]); else pass_cnt++;
        drive_lookup(0, 64'h9000_0010);
        resp_ready[0] = 1'b0;
        total_cnt++; if (resp_hit[0] !== 1'b1) $display("FAIL race_new_hit: got %b want 1", resp_hit[0]); else pass_cnt++;
        total_cnt++; if (resp_attr[0] !== 3'b101) $display("FAIL race_new_attr: got %b want 101", resp_attr[0]); else pass_cnt++;
        cfg_write(1, pma_rule_t'('0));
        total_cnt++; if (resp_valid[0] !== 1'b1) $display("FAIL race_hold_valid: got %b want 1", resp_valid[0]); else pass_cnt++;
        total_cnt++; if (resp_attr[0] !== 3'b101) $display("FAIL race_hold_attr: got %b want 101", resp_attr[0]); else pass_cnt++;
        resp_ready[0] = 1'b1;
        step;
        total_cnt++; if (resp_valid[0] !== 1'b0) $display("FAIL race_drain: got %b want 0", resp_valid[0]); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        resp_ready[1] = 1'b0;
        req_valid[1]  = 1'b1;
        req_addr[1]   = 64'h8000_0010;
        #1;
        total_cnt++; if (req_ready[1] !== 1'b1) $display("FAIL bp_ready_init: got %b want 1", req_ready[1]); else pass_cnt++;
        step;
        // A second acceptance would load this miss address over the held hit.
        req_addr[1] = 64'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total_cnt++; if (req_ready[1] !== 1'b0) $display("FAIL bp_ready_low[%0d]: got %b want 0", i, req_ready[1]); else pass_cnt++;
            total_cnt++; if (resp_valid[1] !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, resp_valid[1]); else pass_cnt++;
            total_cnt++; if (resp_hit[1] !== 1'b1) $display("FAIL bp_hit[%0d]: got %b want 1", i, resp_hit[1]); else pass_cnt++;
            total_cnt++; if (resp_attr[1] !== 3'b110) $display("FAIL bp_attr[%0d]: got %b want 110", i, resp_attr[1]); else pass_cnt++;
            step;
        end
        resp_ready[1] = 1'b1;
        #1;
        total_cnt++; if (req_ready[1] !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", req_ready[1]); else pass_cnt++;
        step;
        req_addr[1] = 64'h8000_0020;
        total_cnt++; if (resp_valid[1] !== 1'b1) $display("FAIL bp_b2b_valid0: got %b want 1", resp_valid[1]); else pass_cnt++;
        total_cnt++; if (resp_attr[1] !== 3'b010) $display("FAIL bp_b2b_attr0: got %b want 010", resp_attr[1]); else pass_cnt++;
        step;
        req_addr[1] = 64'h0;
        total_cnt++; if (resp_valid[1] !== 1'b1) $display("FAIL bp_b2b_valid1: got %b want 1", resp_valid[1]); else pass_cnt++;
        total_cnt++; if (resp_attr[1] !== 3'b110) $display("FAIL bp_b2b_attr1: got %b want 110", resp_attr[1]); else pass_cnt++;
        step;
        req_valid[1] = 1'b0;
        total_cnt++; if (resp_hit[1] !== 1'b0) $display("FAIL bp_b2b_hit2: got %b want 0", resp_hit[1]); else pass_cnt++;
        step;
        total_cnt++; if (resp_valid[1] !== 1'b0) $display("FAIL bp_drain: got %b want 0", resp_valid[1]); else pass_cnt++;
    endtask

    task automatic test_overflow;
        cfg_write(2, mk(1'b1, 1'b0, 3'b100, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20));
        cfg_write(4, mk(1'b1, 1'b0, 3'b111, 64'h0, 64'h0));
        drive_lookup(0, 64'hFFFF_FFFF_FFFF_FFFF);
        total_cnt++; if (resp_hit[0] !== 1'b1) $display("FAIL ovf_top_hit: got %b want 1", resp_hit[0]); else pass_cnt++;
        total_cnt++; if (resp_attr[0] !== 3'b100) $display("FAIL ovf_top_attr: got %b want 100", resp_attr[0]); else pass_cnt++;
        drive_lookup(1, 64'hFFFF_FFFF_FFFF_FFEF);
        total_cnt++; if (resp_hit[1] !== 1'b0) $display("FAIL ovf_below_hit: got %b want 0", resp_hit[1]); else pass_cnt++;
        drive_lookup(1, 64'hFFFF_FFFF_FFFF_FFF0);
        total_cnt++; if (resp_hit[1] !== 1'b1) $display("FAIL ovf_base_hit: got %b want 1", resp_hit[1]); else pass_cnt++;
        drive_lookup(0, 64'h0);
        total_cnt++; if (resp_hit[0] !== 1'b0) $display("FAIL len0_hit: got %b want 0", resp_hit[0]); else pass_cnt++;
        total_cnt++; if (resp_attr[0] !== 3'b010) $display("FAIL len0_attr: got %b want 010", resp_attr[0]); else pass_cnt++;
        cfg_write(2, pma_rule_t'('0));
        cfg_write(4, pma_rule_t'('0));
    endtask

    task automatic test_overlap;
        cfg_write(0, mk(1'b1, 1'b0, 3'b001, 64'hA000_0000, 64'h100));
        cfg_write(1, mk(1'b1, 1'b0, 3'b100, 64'hA000_0000, 64'h100));
        req_valid   = 2'b11;
        req_addr[0] = 64'hA000_0080;
        req_addr[1] = 64'hA000_0080;
        step;
        req_addr[0] = 64'hA000_00FF;
        req_addr[1] = 64'hA000_0100;
        total_cnt++; if (resp_valid !== 2'b11) $display("FAIL ovl_valid: got %b want 11", resp_valid); else pass_cnt++;
        total_cnt++; if (resp_hit !== 2'b11) $display("FAIL ovl_hit: got %b want 11", resp_hit); else pass_cnt++;
        total_cnt++; if (resp_attr[0] !== 3'b101) $display("FAIL ovl_attr0: got %b want 101", resp_attr[0]); else pass_cnt++;
        total_cnt++; if (resp_attr[1] !== 3'b101) $display("FAIL ovl_attr1: got %b want 101", resp_attr[1]); else pass_cnt++;
        step;
        req_valid = 2'b00;
        total_cnt++; if (resp_attr[0] !== 3'b101) $display("FAIL ovl_edge_attr0: got %b want 101", resp_attr[0]); else pass_cnt++;
        total_cnt++; if (resp_hit[1] !== 1'b0) $display("FAIL ovl_end_hit1: got %b want 0", resp_hit[1]); else pass_cnt++;
        total_cnt++; if (resp_attr[1] !== 3'b010) $display("FAIL ovl_end_attr1: got %b want 010", resp_attr[1]); else pass_cnt++;
        step;
        total_cnt++; if (resp_valid !== 2'b00) $display("FAIL ovl_drain: got %b want 00", resp_valid); else pass_cnt++;
    endtask

    initial begin
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_idx    = 4'd0;
        cfg_rule   = '0;
        req_valid  = '0;
        req_addr   = '0;
        resp_ready = 2'b11;
        test_reset;
        test_reset_hit;
        test_lock;
        test_race;
        test_backpressure;
        test_overflow;
        test_overlap;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cva6_pma_checker.md
# cva6_pma_checker

Runtime-programmable, multi-port physical memory attribute (PMA) checker. It replaces the static, elaboration-time region test functions with a register-backed rule table. Each rule carries a base, a length, an attribute set and a lock bit. The block serves `NrPorts` independent lookup channels, each with a valid/ready handshake and a one-cycle registered response. It sits beside the MMU/PMP path, between address translation and the frontend, load-store unit and cache request logic.

## Interface
Parameters:
- `NrRules`, 16: rule table entries (1..16, equal to `NrMaxRules`).
- `NrPorts`, 2: independent lookup channels (1..4).
- `AddrWidth`, 64: physical address width (≤ 64).
- `RstRules`, all-zero: reset image of the table, as `pma_rule_t [NrRules-1:0]`.
- `DefaultAttr`, 3'b010: attribute set returned on a miss (`{cacheable, execute, nonidem}`), so a miss is executable only.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `cfg_we_i` in 1: rule write strobe.
- `cfg_idx_i` in `$clog2(NrRules)`: rule index for the write.
- `cfg_rule_i` in `pma_rule_t`: `{valid, lock, attr[2:0], base[63:0], len[63:0]}`.
- `cfg_err_o` out 1: one-cycle pulse when a write is rejected.
- `cfg_rule_o` out `pma_rule_t [NrRules-1:0]`: current table, for CSR readback.
- `req_valid_i` in `[NrPorts]`: lookup request.
- `req_ready_o` out `[NrPorts]`: channel can accept a request.
- `req_addr_i` in `[NrPorts][AddrWidth]`: address to check.
- `resp_valid_o` out `[NrPorts]`: response valid.
- `resp_ready_i` in `[NrPorts]`: consumer accepts the response.
- `resp_hit_o` out `[NrPorts]`: at least one valid rule matched.
- `resp_attr_o` out `[NrPorts][3]`: resolved attributes.

## Operation
- **Match rule.** Rule k matches address A when `valid` is set, `A >= base` and `{1'b0,A} < 65'(base)+len`. The 65-bit sum prevents overflow, so base=2^64-16, len=32 covers up to the top of the address space. A rule with `len == 0` never matches.
- **Attribute resolution.** Each attribute bit is the OR of that bit over all matching rules. `hit` is the OR of all matches. On a miss, `attr = DefaultAttr`.
- **Rule writes.** On `cfg_we_i`:
  - If the target entry has `lock == 1`, or `cfg_idx_i >= NrRules`, the write is dropped and `cfg_err_o` pulses the next cycle.
  - Otherwise the whole entry is replaced. Setting `lock` makes the entry read-only until reset.
- **Per-channel pipeline.** Each channel has one output register, state IDLE/FULL:
  - `req_ready_o = !resp_valid_o || resp_ready_i`.
  - On a handshake, the response is registered from the table contents of that cycle (the pre-write table).
  - IDLE → FULL on a handshake. FULL → IDLE when `resp_ready_i` is high and no new handshake occurs. FULL stays FULL on a back-to-back handshake, with new data loaded.
- Channels are fully independent. There is no arbitration between them.

## Timing
- Lookup latency is one cycle, with a throughput of one request per cycle per channel.
- A table write in cycle N affects lookups accepted in cycle N+1 or later. `cfg_rule_o` updates in N+1.
- While `resp_valid_o` is high and `resp_ready_i` is low, `resp_hit_o` and `resp_attr_o` hold stable.
- The response register holds the attributes captured at acceptance. A later table write does not change a pending response.
- Reset values:
  - `resp_valid_o = 0`, `resp_hit_o = 0`, `resp_attr_o = 0`.
  - `req_ready_o = 1` in the first cycle after reset deasserts.
  - `cfg_err_o = 0`.
  - Table = `RstRules`, including lock bits.
- Reset asserted mid-transaction discards pending responses with no handshake completion. Reset dominates a simultaneous `cfg_we_i`.

## Structure
- `pma_rule_t` and the attribute bit positions (`PMA_NONIDEM=0`, `PMA_EXEC=1`, `PMA_CACHE=2`) belong in `config_pkg`.
- `range_check` stays in `config_pkg` and is reused unchanged.
- One sub-module, `cva6_pma_lookup`, is the combinational table match and OR-reduce for a single address. It is instantiated `NrPorts` times.
- The rule register file, write and lock logic, and per-channel output registers live in the top module.

## Test plan
- **Reset hit.** `RstRules[0]` = {valid, attr=3'b110, base=0x8000_0000, len=0x1000}; lookup of 0x8000_0FFF returns hit=1, attr=3'b110 after 1 cycle. Lookup of 0x8000_1000 returns hit=0, attr=3'b010.
- **Lock.** Write rule 3 with lock=1, then rewrite rule 3 with a new base: the second write produces a `cfg_err_o` pulse and `cfg_rule_o[3]` is unchanged. After `rst_i` the entry is writable again.
- **Write/lookup race.** Write rule 1 in the same cycle a port 0 request to its range is accepted: the response shows the old table. The same address one cycle later shows the new attributes.
- **Backpressure.** Hold `resp_ready_i[1]=0` for 5 cycles with `req_valid_i[1]=1`: exactly one request is accepted and `req_ready_o[1]=0` with a stable response. Releasing `resp_ready_i[1]` gives back-to-back throughput of 1 per cycle.
- **Top-of-range overflow.** base=0xFFFF_FFFF_FFFF_FFF0, len=0x20: address 0xFFFF_FFFF_FFFF_FFFF hits. A rule with len=0 at base=0 never hits.
- **Overlapping rules.** Rule 0 attr=3'b001 and rule 1 attr=3'b100 over the same range, checked on all ports simultaneously: every port returns attr=3'b101, with identical latency and no cross-port interference.
